bus_arbiter_2m: RTL and testbench

Shares one slave-side req/ack bus between two masters, e.g. instruction fetch (m0) and load/store (m1), in front of the address-decoding slave mux. It uses round-robin arbitration and locks the grant for a whole transaction, until the slave acks. A timeout watchdog returns an error ack if the slave never responds, so no master hangs.

---
 rtl/bus_arb_pkg.sv | 10 +
 rtl/bus_arb_timeout.sv | 20 ++
 rtl/bus_arbiter_2m.sv | 81 ++++++++
 tb/tb_bus_arbiter_2m.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and encodings for the two-master bus arbiter
package bus_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY_M0 = 2'd1, BUSY_M1 = 2'd2} arb_state_t;
    localparam logic CMD_READ = 1'b0;
    localparam logic CMD_WRITE = 1'b1;
    localparam logic [1:0] OWNER_IDLE = 2'd0;
    localparam logic [1:0] OWNER_M0 = 2'd1;
    localparam logic [1:0] OWNER_M1 = 2'd2;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
endpackage

// File: rtl/bus_arb_timeout.sv
// bus_arb_timeout: per-transaction watchdog, expired flags the last allowed un-acked cycle
module bus_arb_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic expired
);
    localparam logic [7:0] LIM = 8'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    logic [7:0] tcnt_q, tcnt_d;
    // saturating at LIM keeps the idle-time count harmless; start clears it on each grant
    always_comb tcnt_d = (start || TIMEOUT == 0) ? 8'd0 : (!ack && tcnt_q != LIM) ? tcnt_q + 8'd1 : tcnt_q;
    always_ff @(posedge clk) begin
        if (rst) tcnt_q <= 8'd0;
        else tcnt_q <= tcnt_d;
    end
    assign expired = (TIMEOUT != 0) && tcnt_q == LIM && !ack;
endmodule

// File: rtl/bus_arbiter_2m.sv
// bus_arbiter_2m: round-robin arbiter sharing one slave req/ack bus between two masters
module bus_arbiter_2m
    import bus_arb_pkg::*;
#(
    parameter int N = 32,
    parameter int TIMEOUT = 16,
    parameter logic [N-1:0] ERR_RDATA = N'(ERR_RDATA_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         m0_req,
    input  logic [N-1:0] m0_addr,
    input  logic         m0_cmd,
    input  logic [N-1:0] m0_wdata,
    output logic         m0_ack,
    output logic [N-1:0] m0_rdata,
    output logic         m0_err,
    input  logic         m1_req,
    input  logic [N-1:0] m1_addr,
    input  logic         m1_cmd,
    input  logic [N-1:0] m1_wdata,
    output logic         m1_ack,
    output logic [N-1:0] m1_rdata,
    output logic         m1_err,
    output logic         s_req,
    output logic [N-1:0] s_addr,
    output logic         s_cmd,
    output logic [N-1:0] s_wdata,
    input  logic         s_ack,
    input  logic [N-1:0] s_rdata,
    output logic [1:0]   owner
);
    arb_state_t state_q, state_d;
    logic last_q, last_d;
    logic busy0, busy1, sel_req, done, tout, expired, grant0, grant1, leave;
    assign busy0 = state_q == BUSY_M0;
    assign busy1 = state_q == BUSY_M1;
    assign sel_req = busy0 ? m0_req : busy1 & m1_req;
    assign done = sel_req & s_ack;
    assign tout = sel_req & expired;
    assign s_req = sel_req & ~expired;
    assign s_addr = busy0 ? m0_addr : busy1 ? m1_addr : '0;
    assign s_cmd = busy0 ? m0_cmd : busy1 & m1_cmd;
    assign s_wdata = busy0 ? m0_wdata : busy1 ? m1_wdata : '0;
    assign m0_ack = busy0 & (done | tout);
    assign m0_err = busy0 & tout;
    assign m0_rdata = !busy0 ? '0 : done ? s_rdata : tout ? ERR_RDATA : '0;
    assign m1_ack = busy1 & (done | tout);
    assign m1_err = busy1 & tout;
    assign m1_rdata = !busy1 ? '0 : done ? s_rdata : tout ? ERR_RDATA : '0;
    assign owner = busy0 ? OWNER_M0 : busy1 ? OWNER_M1 : OWNER_IDLE;
    // on a tie the master that was not served last wins
    assign grant0 = m0_req & (~m1_req | last_q);
    assign grant1 = m1_req & ~grant0;
    assign leave = ~sel_req | s_ack | expired;
    always_comb begin
        state_d = state_q;
        last_d = last_q;
        if (state_q == IDLE) state_d = grant0 ? BUSY_M0 : grant1 ? BUSY_M1 : IDLE;
        else if (leave) begin
            state_d = IDLE;
            last_d = busy1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
        end
    end
    bus_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk(clk),
        .rst(rst),
        .start(state_q == IDLE && (m0_req || m1_req)),
        .ack(s_ack),
        .expired(expired)
    );
endmodule

// File: tb/tb_bus_arbiter_2m.sv
// tb_bus_arbiter_2m: directed plan steps plus random traffic against a transaction-level model
module tb_bus_arbiter_2m;
    localparam int N = 32;
    localparam int TO = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    logic clk = 1'b0, rst;
    logic [1:0] mreq, mcmd;
    logic [N-1:0] maddr[2], mwdata[2];
    logic m0_ack, m1_ack, m0_err, m1_err, s_req, s_cmd, s_ack;
    logic [N-1:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;
    logic [1:0] owner;
    int total = 0, bad = 0;
    int own = 0, lastg = 1, age = 0, prev_own = 0;
    bit leave;
    bit acked[2];
    int dut_grants[$];

    bus_arbiter_2m #(.N(N), .TIMEOUT(TO), .ERR_RDATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .m0_req(mreq[0]), .m0_addr(maddr[0]), .m0_cmd(mcmd[0]), .m0_wdata(mwdata[0]),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(mreq[1]), .m1_addr(maddr[1]), .m1_cmd(mcmd[1]), .m1_wdata(mwdata[1]),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // model: one owner at a time, the transaction ends on ack, dropped request or the TO-th silent cycle
    task automatic settle();
        logic [N-1:0] er[2];
        logic ea[2], ee[2];
        logic esr, esc, req, hit, done;
        logic [N-1:0] esa, esw;
        int x;
        er[0] = '0; er[1] = '0; ea[0] = 0; ea[1] = 0; ee[0] = 0; ee[1] = 0;
        esr = 0; esc = 0; esa = '0; esw = '0; leave = 0;
        @(negedge clk);
        if (own != 0) begin
            x = own - 1;
            req = mreq[x];
            done = req && s_ack;
            hit = req && !s_ack && age == TO - 1;
            esr = req && !hit;
            esa = maddr[x]; esc = mcmd[x]; esw = mwdata[x];
            ea[x] = done || hit;
            ee[x] = hit;
            er[x] = done ? s_rdata : hit ? ERR : '0;
            leave = !req || s_ack || age == TO - 1;
        end
        chk("owner", owner, own);
        chk("slave", {s_req, s_cmd, s_addr, s_wdata}, {esr, esc, esa, esw});
        chk("m0", {m0_ack, m0_err, m0_rdata}, {ea[0], ee[0], er[0]});
        chk("m1", {m1_ack, m1_err, m1_rdata}, {ea[1], ee[1], er[1]});
        acked[0] = ea[0];
        acked[1] = ea[1];
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst) begin
            own = 0; lastg = 1; age = 0;
        end else if (own == 0) begin
            own = (mreq == 2'b11) ? 2 - lastg : mreq[0] ? 1 : mreq[1] ? 2 : 0;
            age = 0;
        end else if (leave) begin
            lastg = own - 1;
            own = 0;
        end else age++;
        #1;
    endtask

    task automatic set_m(input int i, input logic r, input logic [N-1:0] a, input logic c, input logic [N-1:0] w);
        mreq[i] = r; maddr[i] = a; mcmd[i] = c; mwdata[i] = w;
    endtask

    initial begin
        rst = 1; mreq = 0; mcmd = 0; s_ack = 0; s_rdata = '0;
        maddr[0] = '0; maddr[1] = '0; mwdata[0] = '0; mwdata[1] = '0;
        repeat (2) begin settle(); adv(); end
        rst = 0;
        settle();
        chk("rst_owner", owner, 0);
        chk("rst_sreq", s_req, 0);
        adv();
        // single read, slave acks two cycles after s_req
        set_m(0, 1, 32'h10, 0, '0);
        settle(); adv();
        settle(); chk("rd_addr", s_addr, 32'h10); chk("rd_sreq", s_req, 1); adv();
        settle(); adv();
        s_ack = 1; s_rdata = 32'hA5A5_0001;
        settle();
        chk("rd_ack", {m0_ack, m0_err, m0_rdata}, {1'b1, 1'b0, 32'hA5A5_0001});
        chk("rd_m1", m1_ack, 0);
        adv();
        mreq[0] = 0; s_ack = 0;
        // simultaneous request after reset
        rst = 1; settle(); adv(); rst = 0;
        set_m(0, 1, 32'h20, 0, '0);
        set_m(1, 1, 32'h8000_0004, 1, 32'h1234);
        settle(); adv();
        s_ack = 1; s_rdata = 32'h0BAD_F00D;
        settle(); chk("sim_own", owner, 1); chk("sim_m0ack", m0_ack, 1); chk("sim_m1ack", m1_ack, 0); adv();
        mreq[0] = 0; s_ack = 0;
        settle(); chk("bubble", owner, 0); adv();
        settle();
        chk("m1_own", owner, 2);
        chk("m1_bus", {s_cmd, s_addr, s_wdata}, {1'b1, 32'h8000_0004, 32'h1234});
        adv();
        s_ack = 1;
        settle(); chk("m1_ack", m1_ack, 1); adv();
        mreq[1] = 0; s_ack = 0;
        // round-robin with both masters always requesting
        mreq = 2'b11; prev_own = 0; dut_grants.delete();
        for (int c = 0; c < 12; c++) begin
            s_ack = own != 0;
            s_rdata = $urandom;
            settle();
            if (owner != 0 && prev_own == 0) dut_grants.push_back(int'(owner));
            prev_own = int'(owner);
            adv();
        end
        mreq = 0; s_ack = 0;
        chk("rr_count", dut_grants.size(), 6);
        for (int g = 0; g < dut_grants.size() && g < 6; g++) chk("rr_order", dut_grants[g], g % 2 + 1);
        // timeout on a silent slave, then a late ack in idle
        set_m(1, 1, 32'h40, 0, '0);
        settle(); adv();
        for (int k = 0; k < TO; k++) begin
            settle();
            if (k < TO - 1) chk("to_wait", {m1_ack, s_req}, 2'b01);
            else chk("to_err", {m1_ack, m1_err, m1_rdata, s_req}, {1'b1, 1'b1, ERR, 1'b0});
            adv();
        end
        mreq[1] = 0; s_ack = 1; s_rdata = 32'h77;
        settle(); chk("late_ack", {owner, m0_ack, m1_ack}, 4'b0); adv();
        s_ack = 0;
        // ack on the expiry cycle wins
        set_m(0, 1, 32'h44, 0, '0);
        settle(); adv();
        for (int k = 0; k < TO; k++) begin
            s_ack = k == TO - 1; s_rdata = 32'h55;
            settle();
            if (k == TO - 1) chk("ack_wins", {m0_ack, m0_err, m0_rdata}, {1'b1, 1'b0, 32'h55});
            adv();
        end
        mreq[0] = 0; s_ack = 0;
        // reset in the middle of a transaction
        set_m(0, 1, 32'h48, 1, 32'hCAFE);
        settle(); adv();
        settle(); adv();
        rst = 1; settle(); adv(); rst = 0;
        settle(); chk("mid_rst", {owner, s_req, m0_ack}, 4'b0); adv();
        settle(); chk("regrant", owner, 1); adv();
        s_ack = 1; settle(); adv();
        mreq[0] = 0; s_ack = 0;
        // random traffic, including requests dropped before ack
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (acked[i] || (mreq[i] && $urandom_range(49) == 0)) mreq[i] = 0;
                else if (!mreq[i] && $urandom_range(2) == 0) set_m(i, 1, $urandom, 1'($urandom), $urandom);
            end
            s_ack = $urandom_range(2) == 0;
            s_rdata = $urandom;
            settle();
            adv();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
